issue_scheduler: RTL and testbench

ISSUE_SCHEDULER -- requirements
Module: issue_scheduler

---
 rtl/issue_scheduler_pkg.sv | 52 +++++
 rtl/isq_issue_if.sv | 12 +
 rtl/isq_select.sv | 26 ++
 rtl/issue_scheduler.sv | 175 +++++++++++++++++
 tb/tb_issue_scheduler.sv | 387 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/issue_scheduler_pkg.sv
// Shared configuration and types for the issue scheduler slice: machine-wide
// widths live in `parameters`, datapath types and the queue entry in `common`.
package parameters;
    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
endpackage

package common;
    import parameters::*;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;

    typedef enum logic [1:0] {
        OP_TYPE_REG = 2'd0,
        OP_TYPE_IMM = 2'd1,
        OP_TYPE_PC  = 2'd2
    } op_type_t;

    typedef struct packed {
        logic                            busy;
        alu_cmd_t                        alu_cmd;
        logic [31:0]                     op1;
        logic                            op1_rdy;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] tag1;
        op_type_t                        op2_type;
        logic [31:0]                     op2;
        logic                            op2_rdy;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] tag2;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    } isq_entry_t;

    // Ready flag and value of one source operand, ordered to match {rdy, data} pairs.
    typedef struct packed {
        logic        rdy;
        logic [31:0] val;
    } operand_t;

    function automatic logic is_imm(input op_type_t op_type);
        return (op_type == OP_TYPE_IMM);
    endfunction
endpackage

// File: rtl/isq_issue_if.sv
// Issue bundle from the issue queue toward the executers, one slot per lane.
interface isqIssueIf;
    logic             [parameters::DISPATCH_WIDTH-1:0]       valid;
    common::alu_cmd_t [parameters::DISPATCH_WIDTH-1:0]       alu_cmd;
    logic             [parameters::DISPATCH_WIDTH-1:0][31:0] op1;
    common::op_type_t [parameters::DISPATCH_WIDTH-1:0]       op2_type;
    logic             [parameters::DISPATCH_WIDTH-1:0][31:0] op2;
    logic             [parameters::DISPATCH_WIDTH-1:0][parameters::PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;

    modport out (output valid, alu_cmd, op1, op2_type, op2, phys_rd);
    modport in  (input  valid, alu_cmd, op1, op2_type, op2, phys_rd);
endinterface

// File: rtl/isq_select.sv
// Multi-grant priority picker: grant k is the k-th lowest set bit of req.
module isq_select #(
    parameter int NUM_REQ = 8,
    parameter int NUM_GNT = 2
) (
    input  logic [NUM_REQ-1:0]              req,
    output logic [NUM_GNT-1:0][NUM_REQ-1:0] gnt
);
    logic [NUM_REQ-1:0] remain_s;
    logic               found_s;

    // Peel off the lowest remaining request once per grant lane
    always_comb begin
        gnt      = '0;
        remain_s = req;
        found_s  = 1'b0;
        for (int k = 0; k < NUM_GNT; k++) begin
            found_s = 1'b0;
            for (int i = 0; i < NUM_REQ; i++) begin
                gnt[k][i] = remain_s[i] & ~found_s;
                found_s   = found_s | remain_s[i];
            end
            remain_s = remain_s & ~gnt[k];
        end
    end
endmodule

// File: rtl/issue_scheduler.sv
// Unified issue queue: in-order-lane dispatch into free entries, tag-broadcast
// wakeup, and oldest-index-first selection of up to DISPATCH_WIDTH ops per cycle.
module issue_scheduler
    import parameters::*;
    import common::*;
#(
    parameter int ISQ_DEPTH = 8
) (
    input  logic                                                 clk,
    input  logic                                                 rst,
    input  logic                                                 flush,
    input  logic     [DISPATCH_WIDTH-1:0]                        dispatch_valid,
    input  alu_cmd_t [DISPATCH_WIDTH-1:0]                        alu_cmd,
    input  logic     [DISPATCH_WIDTH-1:0][31:0]                  op1,
    input  logic     [DISPATCH_WIDTH-1:0]                        op1_ready,
    input  logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rs1,
    input  op_type_t [DISPATCH_WIDTH-1:0]                        op2_type,
    input  logic     [DISPATCH_WIDTH-1:0][31:0]                  op2,
    input  logic     [DISPATCH_WIDTH-1:0]                        op2_ready,
    input  logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rs2,
    input  logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] phys_rd,
    output logic                                                 dispatch_ready,
    input  logic     [DISPATCH_WIDTH-1:0]                        wb_valid,
    input  logic     [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd,
    input  logic     [DISPATCH_WIDTH-1:0][31:0]                  wb_data,
    isqIssueIf.out                                               issue
);
    localparam int FCW = $clog2(ISQ_DEPTH + 1);
    localparam int SLW = (DISPATCH_WIDTH > 1) ? $clog2(DISPATCH_WIDTH) : 1;

    isq_entry_t                                 entries_r     [ISQ_DEPTH];
    isq_entry_t                                 entries_nxt_s [ISQ_DEPTH];
    isq_entry_t                                 new_entry_s   [DISPATCH_WIDTH];
    isq_entry_t                                 sel_s         [DISPATCH_WIDTH];
    logic       [FCW-1:0]                       free_cnt_r;
    logic       [FCW-1:0]                       free_cnt_nxt_s;
    logic       [FCW-1:0]                       n_issue_s;
    logic       [FCW-1:0]                       n_accept_s;
    logic                                       dispatch_ready_r;
    logic                                       accept_s;
    logic       [ISQ_DEPTH-1:0]                 eligible_s;
    logic       [ISQ_DEPTH-1:0]                 free_vec_s;
    logic       [ISQ_DEPTH-1:0]                 issued_s;
    logic       [DISPATCH_WIDTH-1:0][ISQ_DEPTH-1:0] issue_gnt_s;
    logic       [DISPATCH_WIDTH-1:0][ISQ_DEPTH-1:0] alloc_gnt_s;
    logic       [DISPATCH_WIDTH-1:0][SLW-1:0]   lane_slot_s;
    logic       [DISPATCH_WIDTH-1:0]            issue_valid_s;

    // Lowest wb lane wins when several broadcast the same tag.
    function automatic operand_t wake_operand(
        input logic                            rdy,
        input logic [31:0]                     val,
        input logic [PHYS_REGS_ADDR_WIDTH-1:0] tag
    );
        operand_t res;
        res.rdy = rdy;
        res.val = val;
        for (int w = DISPATCH_WIDTH - 1; w >= 0; w--) begin
            if (!rdy && wb_valid[w] && (wb_phys_rd[w] == tag)) begin
                res.rdy = 1'b1;
                res.val = wb_data[w];
            end
        end
        return res;
    endfunction

    assign dispatch_ready = dispatch_ready_r;
    assign accept_s       = dispatch_ready_r & ~flush;

    // Request vectors for selection and allocation, from registered state only
    always_comb begin
        eligible_s = '0;
        free_vec_s = '0;
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            eligible_s[i] = entries_r[i].busy & entries_r[i].op1_rdy & entries_r[i].op2_rdy;
            free_vec_s[i] = ~entries_r[i].busy;
        end
    end

    isq_select #(.NUM_REQ(ISQ_DEPTH), .NUM_GNT(DISPATCH_WIDTH)) u_issue_select (
        .req (eligible_s),
        .gnt (issue_gnt_s)
    );

    isq_select #(.NUM_REQ(ISQ_DEPTH), .NUM_GNT(DISPATCH_WIDTH)) u_alloc_select (
        .req (free_vec_s),
        .gnt (alloc_gnt_s)
    );

    // One-hot payload mux per issue lane; flush suppresses every lane
    always_comb begin
        issue_valid_s = '0;
        issued_s      = '0;
        n_issue_s     = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            sel_s[k] = '0;
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                sel_s[k] = sel_s[k] | ({$bits(isq_entry_t){issue_gnt_s[k][i]}} & entries_r[i]);
            end
            issue_valid_s[k] = (|issue_gnt_s[k]) & ~flush;
            issued_s         = issued_s | (issue_gnt_s[k] & {ISQ_DEPTH{~flush}});
            n_issue_s        = n_issue_s + FCW'(issue_valid_s[k]);
        end
    end

    assign issue.valid = issue_valid_s;

    for (genvar k = 0; k < DISPATCH_WIDTH; k++) begin : g_issue_lane
        assign issue.alu_cmd[k]  = sel_s[k].alu_cmd;
        assign issue.op1[k]      = sel_s[k].op1;
        assign issue.op2_type[k] = sel_s[k].op2_type;
        assign issue.op2[k]      = sel_s[k].op2;
        assign issue.phys_rd[k]  = sel_s[k].phys_rd;
    end

    // Dispatch payload with same-cycle wakeup; slot k is the count of earlier accepted lanes
    always_comb begin
        n_accept_s  = '0;
        lane_slot_s = '0;
        for (int k = 0; k < DISPATCH_WIDTH; k++) begin
            lane_slot_s[k]          = SLW'(n_accept_s);
            new_entry_s[k].busy     = 1'b1;
            new_entry_s[k].alu_cmd  = alu_cmd[k];
            new_entry_s[k].tag1     = phys_rs1[k];
            new_entry_s[k].op2_type = op2_type[k];
            new_entry_s[k].tag2     = phys_rs2[k];
            new_entry_s[k].phys_rd  = phys_rd[k];
            {new_entry_s[k].op1_rdy, new_entry_s[k].op1} =
                wake_operand(op1_ready[k], op1[k], phys_rs1[k]);
            {new_entry_s[k].op2_rdy, new_entry_s[k].op2} =
                wake_operand(op2_ready[k] | is_imm(op2_type[k]), op2[k], phys_rs2[k]);
            n_accept_s = n_accept_s + FCW'(accept_s & dispatch_valid[k]);
        end
    end

    // Next entry state: wakeup stored operands, retire issued entries, write dispatched ones
    always_comb begin
        for (int i = 0; i < ISQ_DEPTH; i++) begin
            entries_nxt_s[i] = entries_r[i];
            {entries_nxt_s[i].op1_rdy, entries_nxt_s[i].op1} =
                wake_operand(entries_r[i].op1_rdy, entries_r[i].op1, entries_r[i].tag1);
            {entries_nxt_s[i].op2_rdy, entries_nxt_s[i].op2} =
                wake_operand(entries_r[i].op2_rdy, entries_r[i].op2, entries_r[i].tag2);
            entries_nxt_s[i].busy = entries_r[i].busy & ~issued_s[i] & ~flush;
            for (int k = 0; k < DISPATCH_WIDTH; k++) begin
                entries_nxt_s[i] = (accept_s && dispatch_valid[k] && alloc_gnt_s[lane_slot_s[k]][i])
                                   ? new_entry_s[k] : entries_nxt_s[i];
            end
        end
    end

    // Free-slot bookkeeping; accept is gated by flush so a flush simply restores the full count
    always_comb begin
        if (flush) begin
            free_cnt_nxt_s = FCW'(ISQ_DEPTH);
        end else begin
            free_cnt_nxt_s = free_cnt_r + n_issue_s - n_accept_s;
        end
    end

    // State registers; payload fields are intentionally left unreset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ISQ_DEPTH; i++) begin
                entries_r[i].busy <= 1'b0;
            end
            free_cnt_r       <= FCW'(ISQ_DEPTH);
            dispatch_ready_r <= 1'b1;
        end else begin
            entries_r        <= entries_nxt_s;
            free_cnt_r       <= free_cnt_nxt_s;
            dispatch_ready_r <= (free_cnt_nxt_s >= FCW'(DISPATCH_WIDTH));
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: dispatch, wakeup, selection order,
// full-queue back-pressure and flush, each with hand-computed expectations.
module tb_issue_scheduler;
    import parameters::*;
    import common::*;

    localparam int DW  = DISPATCH_WIDTH;
    localparam int PRW = PHYS_REGS_ADDR_WIDTH;

    logic                          clk;
    logic                          rst;
    logic                          flush;
    logic     [DW-1:0]             dispatch_valid;
    alu_cmd_t [DW-1:0]             alu_cmd;
    logic     [DW-1:0][31:0]       op1;
    logic     [DW-1:0]             op1_ready;
    logic     [DW-1:0][PRW-1:0]    phys_rs1;
    op_type_t [DW-1:0]             op2_type;
    logic     [DW-1:0][31:0]       op2;
    logic     [DW-1:0]             op2_ready;
    logic     [DW-1:0][PRW-1:0]    phys_rs2;
    logic     [DW-1:0][PRW-1:0]    phys_rd;
    logic                          dispatch_ready;
    logic     [DW-1:0]             wb_valid;
    logic     [DW-1:0][PRW-1:0]    wb_phys_rd;
    logic     [DW-1:0][31:0]       wb_data;

    int checks = 0;
    int fails  = 0;

    isqIssueIf issue_if ();

    issue_scheduler #(.ISQ_DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .dispatch_valid (dispatch_valid),
        .alu_cmd        (alu_cmd),
        .op1            (op1),
        .op1_ready      (op1_ready),
        .phys_rs1       (phys_rs1),
        .op2_type       (op2_type),
        .op2            (op2),
        .op2_ready      (op2_ready),
        .phys_rs2       (phys_rs2),
        .phys_rd        (phys_rd),
        .dispatch_ready (dispatch_ready),
        .wb_valid       (wb_valid),
        .wb_phys_rd     (wb_phys_rd),
        .wb_data        (wb_data),
        .issue          (issue_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_inputs();
        dispatch_valid = '0;
        flush          = 1'b0;
        wb_valid       = '0;
        for (int k = 0; k < DW; k++) begin
            alu_cmd[k]    = ALU_ADD;
            op1[k]        = 32'h0;
            op1_ready[k]  = 1'b0;
            phys_rs1[k]   = '0;
            op2_type[k]   = OP_TYPE_REG;
            op2[k]        = 32'h0;
            op2_ready[k]  = 1'b0;
            phys_rs2[k]   = '0;
            phys_rd[k]    = '0;
            wb_phys_rd[k] = '0;
            wb_data[k]    = 32'h0;
        end
    endtask

    task automatic drive_lane(input int k, input alu_cmd_t c,
                              input logic [31:0] a, input logic ar, input logic [PRW-1:0] ta,
                              input op_type_t t, input logic [31:0] b, input logic br,
                              input logic [PRW-1:0] tb2, input logic [PRW-1:0] rd);
        dispatch_valid[k] = 1'b1;
        alu_cmd[k]        = c;
        op1[k]            = a;
        op1_ready[k]      = ar;
        phys_rs1[k]       = ta;
        op2_type[k]       = t;
        op2[k]            = b;
        op2_ready[k]      = br;
        phys_rs2[k]       = tb2;
        phys_rd[k]        = rd;
    endtask

    task automatic drive_wb(input int k, input logic [PRW-1:0] tag, input logic [31:0] d);
        wb_valid[k]   = 1'b1;
        wb_phys_rd[k] = tag;
        wb_data[k]    = d;
    endtask

    // Advance one clock; inputs return to idle just after the edge.
    task automatic next_cycle();
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        drive_lane(0, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h2, 1'b1, 6'd0, 6'd1);
        drive_lane(1, ALU_ADD, 32'h3, 1'b1, 6'd0, OP_TYPE_REG, 32'h4, 1'b1, 6'd0, 6'd2);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        clear_inputs();
        #1;
        checks++;
        if (dispatch_ready !== 1'b1) begin
            $display("FAIL reset_ready: got %0b expected 1", dispatch_ready); fails++;
        end
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL reset_valid: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
    endtask

    task automatic test_dispatch_pair();
        drive_lane(0, ALU_ADD, 32'h11, 1'b1, 6'd0, OP_TYPE_REG, 32'h22, 1'b1, 6'd0, 6'd5);
        drive_lane(1, ALU_ADD, 32'h33, 1'b1, 6'd0, OP_TYPE_REG, 32'h44, 1'b1, 6'd0, 6'd6);
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL pair_no_bypass: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b11) begin
            $display("FAIL pair_valid: got %b expected 11", issue_if.valid); fails++;
        end
        checks++;
        if ({issue_if.phys_rd[1], issue_if.phys_rd[0]} !== {6'd6, 6'd5}) begin
            $display("FAIL pair_rd: got %0d/%0d expected 5/6", issue_if.phys_rd[0], issue_if.phys_rd[1]); fails++;
        end
        checks++;
        if (issue_if.op1[0] !== 32'h11 || issue_if.op2[1] !== 32'h44 || issue_if.alu_cmd[0] !== ALU_ADD) begin
            $display("FAIL pair_payload: got op1=%h op2=%h cmd=%0d expected 11/44/0",
                     issue_if.op1[0], issue_if.op2[1], issue_if.alu_cmd[0]); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00 || dispatch_ready !== 1'b1) begin
            $display("FAIL pair_empty: got valid=%b ready=%b expected 00/1", issue_if.valid, dispatch_ready); fails++;
        end
        next_cycle();
    endtask

    task automatic test_wakeup();
        drive_lane(0, ALU_SUB, 32'hDEADBEEF, 1'b0, 6'd9, OP_TYPE_REG, 32'h5, 1'b1, 6'd0, 6'd10);
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL wake_waiting: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        drive_wb(0, 6'd9, 32'h1234);
        drive_wb(1, 6'd9, 32'hBAD0);
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL wake_same_cycle: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b01) begin
            $display("FAIL wake_issue: got %b expected 01", issue_if.valid); fails++;
        end
        checks++;
        if (issue_if.op1[0] !== 32'h1234) begin
            $display("FAIL wake_data: got %h expected 00001234", issue_if.op1[0]); fails++;
        end
        checks++;
        if (issue_if.phys_rd[0] !== 6'd10 || issue_if.alu_cmd[0] !== ALU_SUB) begin
            $display("FAIL wake_payload: got rd=%0d cmd=%0d expected 10/1", issue_if.phys_rd[0], issue_if.alu_cmd[0]); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL wake_drained: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
    endtask

    task automatic test_dispatch_wakeup();
        drive_lane(0, ALU_OR,  32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'hFFFF, 1'b0, 6'd7, 6'd12);
        drive_lane(1, ALU_AND, 32'h2, 1'b1, 6'd0, OP_TYPE_IMM, 32'h64,   1'b0, 6'd3, 6'd13);
        drive_wb(1, 6'd7, 32'h77);
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b11) begin
            $display("FAIL dwake_valid: got %b expected 11", issue_if.valid); fails++;
        end
        checks++;
        if (issue_if.op2[0] !== 32'h77) begin
            $display("FAIL dwake_data: got %h expected 00000077", issue_if.op2[0]); fails++;
        end
        checks++;
        if (issue_if.op2[1] !== 32'h64 || issue_if.op2_type[1] !== OP_TYPE_IMM || issue_if.phys_rd[1] !== 6'd13) begin
            $display("FAIL dwake_imm: got op2=%h type=%0d rd=%0d expected 64/1/13",
                     issue_if.op2[1], issue_if.op2_type[1], issue_if.phys_rd[1]); fails++;
        end
        next_cycle();
    endtask

    task automatic test_fill();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 2; k++) begin
                drive_lane(k, ALU_XOR, 32'h0, 1'b0, PRW'(20 + 2 * c + k), OP_TYPE_IMM,
                           32'h0, 1'b0, 6'd0, PRW'(30 + 2 * c + k));
            end
            #1;
            checks++;
            if (dispatch_ready !== 1'b1) begin
                $display("FAIL fill_ready_%0d: got %b expected 1", c, dispatch_ready); fails++;
            end
            next_cycle();
        end
        drive_lane(0, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd40);
        drive_lane(1, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd41);
        #1;
        checks++;
        if (dispatch_ready !== 1'b0) begin
            $display("FAIL full_ready: got %b expected 0", dispatch_ready); fails++;
        end
        next_cycle();
        drive_wb(0, 6'd20, 32'h5);
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL full_ignored: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b01 || issue_if.phys_rd[0] !== 6'd30 || dispatch_ready !== 1'b0) begin
            $display("FAIL full_wake_issue: got valid=%b rd=%0d ready=%b expected 01/30/0",
                     issue_if.valid, issue_if.phys_rd[0], dispatch_ready); fails++;
        end
        next_cycle();
        drive_lane(0, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd42);
        drive_lane(1, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd43);
        #1;
        checks++;
        if (dispatch_ready !== 1'b0) begin
            $display("FAIL free1_ready: got %b expected 0", dispatch_ready); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL free1_ignored: got %b expected 00", issue_if.valid); fails++;
        end
        flush = 1'b1;
        next_cycle();
        #1;
        checks++;
        if (dispatch_ready !== 1'b1) begin
            $display("FAIL fill_flush_ready: got %b expected 1", dispatch_ready); fails++;
        end
        next_cycle();
    endtask

    task automatic test_select_order();
        for (int c = 0; c < 4; c++) begin
            for (int k = 0; k < 2; k++) begin
                int i;
                i = 2 * c + k;
                drive_lane(k, ALU_SLT, 32'h0, 1'b0, ((i == 1) || (i == 4) || (i == 6)) ? 6'd40 : 6'd41,
                           OP_TYPE_IMM, 32'(i), 1'b0, 6'd0, PRW'(50 + i));
            end
            next_cycle();
        end
        drive_wb(0, 6'd40, 32'h40);
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL sel_idle: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b11 || {issue_if.phys_rd[1], issue_if.phys_rd[0]} !== {6'd54, 6'd51}) begin
            $display("FAIL sel_first: got valid=%b rd=%0d/%0d expected 11 51/54",
                     issue_if.valid, issue_if.phys_rd[0], issue_if.phys_rd[1]); fails++;
        end
        checks++;
        if (issue_if.op1[0] !== 32'h40 || issue_if.op2[1] !== 32'h4) begin
            $display("FAIL sel_first_data: got op1=%h op2=%h expected 40/4", issue_if.op1[0], issue_if.op2[1]); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b01 || issue_if.phys_rd[0] !== 6'd56 || issue_if.op2[0] !== 32'h6) begin
            $display("FAIL sel_second: got valid=%b rd=%0d op2=%h expected 01/56/6",
                     issue_if.valid, issue_if.phys_rd[0], issue_if.op2[0]); fails++;
        end
        flush = 1'b1;
        next_cycle();
    endtask

    task automatic test_flush();
        for (int n = 0; n < 5; n++) begin
            drive_lane(n % 2, ALU_SRA, 32'h0, 1'b0, 6'd60, OP_TYPE_IMM, 32'h0, 1'b0, 6'd0, PRW'(70 + n));
            if (n % 2 == 1 || n == 4) next_cycle();
        end
        drive_wb(0, 6'd60, 32'h60);
        next_cycle();
        flush = 1'b1;
        drive_lane(0, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd20);
        drive_lane(1, ALU_ADD, 32'h1, 1'b1, 6'd0, OP_TYPE_REG, 32'h1, 1'b1, 6'd0, 6'd21);
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL flush_valid: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00 || dispatch_ready !== 1'b1) begin
            $display("FAIL flush_cleared: got valid=%b ready=%b expected 00/1", issue_if.valid, dispatch_ready); fails++;
        end
        next_cycle();
        #1;
        checks++;
        if (issue_if.valid !== 2'b00) begin
            $display("FAIL flush_stays_empty: got %b expected 00", issue_if.valid); fails++;
        end
        next_cycle();
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 4; c++) begin
            if (c < 3) begin
                drive_lane(0, ALU_ADD, 32'(c), 1'b1, 6'd0, OP_TYPE_REG, 32'h0, 1'b1, 6'd0, PRW'(40 + 2 * c));
                drive_lane(1, ALU_ADD, 32'(c), 1'b1, 6'd0, OP_TYPE_REG, 32'h0, 1'b1, 6'd0, PRW'(41 + 2 * c));
            end
            #1;
            if (c > 0) begin
                checks++;
                if (issue_if.valid !== 2'b11 || issue_if.phys_rd[0] !== PRW'(40 + 2 * (c - 1))
                    || issue_if.phys_rd[1] !== PRW'(41 + 2 * (c - 1))) begin
                    $display("FAIL b2b_%0d: got valid=%b rd=%0d/%0d expected 11 %0d/%0d", c, issue_if.valid,
                             issue_if.phys_rd[0], issue_if.phys_rd[1], 40 + 2 * (c - 1), 41 + 2 * (c - 1)); fails++;
                end
            end
            next_cycle();
        end
        #1;
        checks++;
        if (issue_if.valid !== 2'b00 || dispatch_ready !== 1'b1) begin
            $display("FAIL b2b_drained: got valid=%b ready=%b expected 00/1", issue_if.valid, dispatch_ready); fails++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_dispatch_pair();
        test_wakeup();
        test_dispatch_wakeup();
        test_fill();
        test_select_order();
        test_flush();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
